// File: rtl/bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// bus_arbiter_if -- requester and shared-bus signals of the round-robin arbiter.
//
//   req_valid [NREQ]     requester i has an address pending
//   req_addr  [NREQ*AW]  address of requester i in bits [i*AW +: AW]
//   req_ready [NREQ]     one-cycle pulse: requester i's address was accepted
//   bus_valid            shared bus carries a valid address
//   bus_addr  [AW]       shared bus address, zero when bus_valid=0
//   bus_owner [3]        index of the granted requester
//   bus_ack              bus target consumed bus_addr
//   bus_err              one-cycle pulse on ack timeout
//
// Modports:
//   master -- the arbiter itself (it masters the shared bus)
//   slave  -- the environment: requesters plus the bus target
// -----------------------------------------------------------------------------
interface bus_arbiter_if #(
  parameter int NREQ = 4,
  parameter int AW   = 8
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ-1:0]    req_ready;
  logic               bus_valid;
  logic [AW-1:0]      bus_addr;
  logic [2:0]         bus_owner;
  logic               bus_ack;
  logic               bus_err;

  modport master (
    input  req_valid, req_addr, bus_ack,
    output req_ready, bus_valid, bus_addr, bus_owner, bus_err
  );

  modport slave (
    output req_valid, req_addr, bus_ack,
    input  req_ready, bus_valid, bus_addr, bus_owner, bus_err
  );
endinterface

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter -- round-robin arbiter granting NREQ requesters onto a single
// shared address bus, with an ack timeout.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-low reset
//   bus  bus_arbiter_if.master (requester handshake + shared bus)
//
// Flow: IDLE picks the first valid requester at or after rr_ptr and latches
// its address onto the bus; BUSY holds the bus until bus_ack or timeout;
// TURN is a mandatory one-cycle gap before the next arbitration.
// -----------------------------------------------------------------------------
module bus_arbiter #(
  parameter int NREQ    = 4,
  parameter int AW      = 8,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  bus_arbiter_if.master bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] TURN = 2'd2;

  logic [1:0]      state;
  logic [2:0]      rr_ptr;
  logic [7:0]      timer;

  logic [NREQ-1:0] req_ready_q;
  logic            bus_valid_q;
  logic [AW-1:0]   bus_addr_q;
  logic [2:0]      bus_owner_q;
  logic            bus_err_q;

  // Round-robin selection
  logic            sel_found;
  logic [2:0]      sel_idx;
  logic [AW-1:0]   sel_addr;
  logic [3:0]      cand;
  logic [NREQ-1:0] rv_shift;

  // NOTE: every variable gets a default at the top of the always_comb so no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_addr  = '0;
    cand      = '0;
    rv_shift  = '0;
    // Scan offsets 0..NREQ-1 from rr_ptr; the first hit wins.
    for (int k = 0; k < NREQ; k++) begin
      cand = 4'(rr_ptr) + 4'(k);
      if (cand >= 4'(NREQ)) cand = cand - 4'(NREQ);
      rv_shift = bus.req_valid >> cand;
      if (!sel_found && rv_shift[0]) begin
        sel_found = 1'b1;
        sel_idx   = cand[2:0];
      end
    end
    for (int k = 0; k < NREQ; k++) begin
      if (3'(k) == sel_idx) sel_addr = bus.req_addr[k*AW +: AW];
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      timer       <= '0;
      req_ready_q <= '0;
      bus_valid_q <= 1'b0;
      bus_addr_q  <= '0;
      bus_owner_q <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      // Both pulses are single-cycle unless re-asserted below.
      req_ready_q <= '0;
      bus_err_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (sel_found) begin
            state       <= BUSY;
            bus_valid_q <= 1'b1;
            bus_addr_q  <= sel_addr;
            bus_owner_q <= sel_idx;
            req_ready_q <= {{(NREQ-1){1'b0}}, 1'b1} << sel_idx;
            timer       <= '0;
          end
        end
        BUSY: begin
          timer <= timer + 8'd1;
          // Ack beats timeout when both land on the same edge.
          if (bus.bus_ack || timer == 8'(TIMEOUT - 1)) begin
            bus_err_q   <= !bus.bus_ack;
            bus_valid_q <= 1'b0;
            bus_addr_q  <= '0;
            rr_ptr      <= (bus_owner_q == 3'(NREQ - 1)) ? 3'd0 : bus_owner_q + 3'd1;
            timer       <= '0;
            state       <= TURN;
          end
        end
        TURN:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.bus_valid = bus_valid_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_owner = bus_owner_q;
  assign bus.bus_err   = bus_err_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter -- directed self-checking bench for bus_arbiter.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// at the same point, after the registers have settled.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;
  localparam int NREQ    = 4;
  localparam int AW      = 8;
  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bus_arbiter_if #(.NREQ(NREQ), .AW(AW)) bif ();

  bus_arbiter #(.NREQ(NREQ), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.master)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    bif.req_addr[i*AW +: AW] = a;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, " valid"}, 32'(bif.bus_valid), 32'd0);
    check({tag, " addr"},  32'(bif.bus_addr),  32'd0);
    check({tag, " ready"}, 32'(bif.req_ready), 32'd0);
    check({tag, " err"},   32'(bif.bus_err),   32'd0);
  endtask

  // One transaction: grant seen after the next edge, bus held for
  // busy_cycles, then acked; ends in IDLE after the TURN cycle.
  task automatic grant(input string tag, input int exp_owner,
                       input logic [AW-1:0] exp_addr, input int busy_cycles);
    step();
    check({tag, " valid"}, 32'(bif.bus_valid), 32'd1);
    check({tag, " addr"},  32'(bif.bus_addr),  32'(exp_addr));
    check({tag, " owner"}, 32'(bif.bus_owner), 32'(exp_owner));
    check({tag, " ready"}, 32'(bif.req_ready), 32'd1 << exp_owner);
    bif.req_valid[exp_owner] = 1'b0;
    set_addr(exp_owner, ~exp_addr);  // must not disturb the latched address
    for (int c = 1; c < busy_cycles; c++) begin
      step();
      check({tag, " hold valid"}, 32'(bif.bus_valid), 32'd1);
      check({tag, " hold addr"},  32'(bif.bus_addr),  32'(exp_addr));
      check({tag, " hold ready"}, 32'(bif.req_ready), 32'd0);
    end
    bif.bus_ack = 1'b1;
    step();
    check_quiet({tag, " turn"});
    check({tag, " turn owner"}, 32'(bif.bus_owner), 32'(exp_owner));
    bif.bus_ack = 1'b0;
    step();
    check({tag, " idle valid"}, 32'(bif.bus_valid), 32'd0);
  endtask

  initial begin
    int exp_order [5] = '{0, 1, 2, 3, 0};

    bif.req_valid = '0;
    bif.req_addr  = '0;
    bif.bus_ack   = 1'b0;

    // Reset state
    #2 rst = 1'b0;
    #1 check_quiet("reset");
    check("reset owner", 32'(bif.bus_owner), 32'd0);
    step();
    step();
    rst = 1'b1;
    step();
    check_quiet("idle no req");

    // Full contention, ack held high (also ignored in IDLE/TURN)
    for (int i = 0; i < NREQ; i++) set_addr(i, 8'(8'h10 + i));
    bif.req_valid = 4'b1111;
    bif.bus_ack   = 1'b1;
    for (int n = 0; n < 5; n++) begin
      step();
      check($sformatf("rr%0d owner", n), 32'(bif.bus_owner), 32'(exp_order[n]));
      check($sformatf("rr%0d valid", n), 32'(bif.bus_valid), 32'd1);
      check($sformatf("rr%0d ready", n), 32'(bif.req_ready), 32'd1 << exp_order[n]);
      check($sformatf("rr%0d addr", n),  32'(bif.bus_addr),  32'h10 + 32'(exp_order[n]));
      step();
      check($sformatf("rr%0d turn valid", n), 32'(bif.bus_valid), 32'd0);
      step();
      check($sformatf("rr%0d idle valid", n), 32'(bif.bus_valid), 32'd0);
    end
    bif.req_valid = '0;
    bif.bus_ack   = 1'b0;

    // Single request, ack after two bus_valid cycles (rr_ptr=1 -> wraps to 0)
    set_addr(0, 8'h3C);
    bif.req_valid = 4'b0001;
    grant("single", 0, 8'h3C, 2);

    // rr_ptr must now be 1
    set_addr(1, 8'h11);
    bif.req_valid = 4'b0011;
    grant("ptr1", 1, 8'h11, 1);

    // rr_ptr=2: requester 0 still pending, requester 2 goes first
    set_addr(0, 8'hA0);
    set_addr(2, 8'hA2);
    bif.req_valid = 4'b0101;
    grant("ptr2", 2, 8'hA2, 1);

    // Wrap from rr_ptr=3: 0 then 2
    set_addr(2, 8'hA2);
    bif.req_valid = 4'b0101;
    grant("wrap0", 0, 8'hA0, 1);
    grant("wrap2", 2, 8'hA2, 1);

    // Timeout: 15 BUSY cycles with no ack
    set_addr(1, 8'h5A);
    bif.req_valid = 4'b0010;
    step();
    check("to owner", 32'(bif.bus_owner), 32'd1);
    check("to valid", 32'(bif.bus_valid), 32'd1);
    bif.req_valid = '0;
    for (int c = 1; c < TIMEOUT; c++) begin
      step();
      check($sformatf("to busy%0d valid", c), 32'(bif.bus_valid), 32'd1);
      check($sformatf("to busy%0d err", c),   32'(bif.bus_err),   32'd0);
    end
    step();
    check("to err",   32'(bif.bus_err),   32'd1);
    check("to valid", 32'(bif.bus_valid), 32'd0);
    check("to addr",  32'(bif.bus_addr),  32'd0);
    step();
    check("to err cleared", 32'(bif.bus_err), 32'd0);

    // rr_ptr advanced past 1 after the timeout
    set_addr(2, 8'h66);
    bif.req_valid = 4'b0110;
    grant("after to", 2, 8'h66, 1);
    bif.req_valid = '0;

    // Ack on the timeout cycle wins
    set_addr(0, 8'h77);
    bif.req_valid = 4'b0001;
    step();
    check("ackto owner", 32'(bif.bus_owner), 32'd0);
    bif.req_valid = '0;
    for (int c = 1; c < TIMEOUT; c++) begin
      step();
      check($sformatf("ackto busy%0d valid", c), 32'(bif.bus_valid), 32'd1);
    end
    bif.bus_ack = 1'b1;
    step();
    check("ackto err",   32'(bif.bus_err),   32'd0);
    check("ackto valid", 32'(bif.bus_valid), 32'd0);
    bif.bus_ack = 1'b0;
    step();
    check("ackto err idle", 32'(bif.bus_err), 32'd0);

    // Reset mid-BUSY (rr_ptr=1 -> requester 2)
    set_addr(2, 8'h42);
    bif.req_valid = 4'b0100;
    step();
    check("mid owner", 32'(bif.bus_owner), 32'd2);
    bif.req_valid = '0;
    step();
    check("mid valid", 32'(bif.bus_valid), 32'd1);
    #2 rst = 1'b0;
    #1 check_quiet("async rst");
    check("async rst owner", 32'(bif.bus_owner), 32'd0);
    step();
    check_quiet("rst held");
    rst = 1'b1;
    set_addr(1, 8'h21);
    bif.req_valid = 4'b0010;
    grant("post rst", 1, 8'h21, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
